iomem_count_master: RTL and testbench
=====================================

Name: iomem_count_master

Overview:
- Autonomous initiator on the PicoSoC iomem peripheral bus; the requesting end of the valid/ready protocol the GPIO responder answers.
- On each periodic tick, reads the GPIO status word (bit0 second_toggle, bit1 UP_DOWN, bit2 START_STOP).
- If counting is enabled, steps a 16-bit counter up or down and writes it to GPIO[15:0], which drives the display. This removes the CPU from the counting loop.

Parameters:
- TICK_CYCLES, 16000000, clk cycles between counting ticks (1 s at 16 MHz); must be >=2.
- GPIO_ADDR, 32'h0300_0000, address used for both the status read and the count write.
- TIMEOUT, 64, max cycles valid may wait for ready before the transaction is abandoned.
- COUNT_INIT, 16'h0000, counter value after reset.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  high = accept ticks; low = no new transactions; an in-flight transaction completes.
- iomem_valid  out  1  request valid.
- iomem_ready  in  1  responder acknowledge, one-cycle pulse.
- iomem_wstrb  out  4  byte strobes; 4'b0000 = read.
- iomem_addr  out  32  request address.
- iomem_wdata  out  32  write data.
- iomem_rdata  in  32  read data, valid in the ready cycle.
- count  out  16  last acknowledged count value.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky; set on timeout.
- overrun  out  1  sticky; set when a tick is dropped.
- err_clr  in  1  single-cycle pulse; clears err and overrun.

Behaviour:
- Reset (sync, high):
  - iomem_valid=0, wstrb=0, addr=0, wdata=0.
  - count=COUNT_INIT; busy/err/overrun=0.
  - tick counter=TICK_CYCLES-1; pending=0; state=IDLE.
  - Reset mid-transaction drops valid on the next edge; no retry.
- Tick counter:
  - Free-running down-counter; produces a one-cycle tick when it reaches 0, then reloads TICK_CYCLES-1.
  - Counts regardless of enable.
- Pending:
  - A tick with enable=1 sets pending.
  - A tick arriving while pending is already 1 is dropped and sets overrun.
  - A tick with enable=0 is ignored; overrun is not set.
- FSM states: IDLE, RD, EVAL, WR.
  - IDLE: if pending, clear pending, go RD. Outputs registered.
  - RD: valid=1, addr=GPIO_ADDR, wstrb=0. On a cycle with ready=1:
    - capture rdata[2:0] into stat;
    - drop valid on the next edge;
    - go EVAL.
  - EVAL (1 cycle):
    - If stat[2]=0, go IDLE with no write.
    - Otherwise next = stat[1] ? count+1 : count-1, mod 2^16. 0xFFFF+1 wraps to 0x0000; 0x0000-1 wraps to 0xFFFF.
    - Then go WR.
  - WR: valid=1, addr=GPIO_ADDR, wstrb=4'b0011, wdata={16'h0000,next}. On ready=1:
    - count<=next;
    - drop valid;
    - go IDLE.
- Handshake rules:
  - addr/wstrb/wdata are stable while valid=1.
  - valid falls the cycle after ready is seen.
  - ready seen while not in RD/WR is ignored.
- Timeout:
  - A wait counter runs in RD and WR.
  - If TIMEOUT cycles pass without ready: valid<=0, err<=1, go IDLE, count unchanged.
  - A ready arriving in the same cycle as expiry wins; no error.
- err_clr clears err and overrun. If set and clear occur in the same cycle, set wins.
- Latency, tick to count update, with ready on the first valid cycle: tick → IDLE → RD (1 cycle) → EVAL → WR (1 cycle) → count updates. Approx. 5 cycles.

Test Plan:
- TICK_CYCLES=8; responder acks in 1 cycle with rdata=3'b110 (start, up); count starts 0x0000 → after 3 ticks count=0x0003; writes carry wdata=0x00000001/2/3 with wstrb=0011.
- rdata=3'b100 (start, down), COUNT_INIT=0x0000 → first write wdata=0x0000FFFF, count=0xFFFF; with up and COUNT_INIT=0xFFFF → count=0x0000.
- rdata bit2=0 → only reads are issued (wstrb=0000); no write seen; count is held.
- Responder never asserts ready, TIMEOUT=4 → valid is high exactly 4 cycles then low; err=1; count unchanged; err_clr pulse → err=0.
- Responder delays ready 20 cycles with TICK_CYCLES=8 → pending absorbs one tick; a further tick sets overrun=1; the transaction then completes normally.
- reset asserted while valid=1 in WR → next edge valid=0 and count=COUNT_INIT; enable=0 → no valid for 3 tick periods.

Source files
------------

// File: rtl/iomem_count_master.sv
// -----------------------------------------------------------------------------
// iomem_count_master
//
// Autonomous initiator on the PicoSoC iomem valid/ready bus. Every TICK_CYCLES
// clocks it reads the GPIO status word (bit0 second_toggle, bit1 UP_DOWN,
// bit2 START_STOP). When START_STOP is set it steps a 16-bit counter up or
// down (modulo 2^16) and writes the new value to GPIO[15:0], which drives the
// display. The CPU is no longer involved in the counting loop.
//
// Parameters
//   TICK_CYCLES : clk cycles between counting ticks (must be >= 2)
//   GPIO_ADDR   : address used for both the status read and the count write
//   TIMEOUT     : cycles valid may wait for ready before the access is dropped
//   COUNT_INIT  : counter value after reset
//
// Ports
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   enable       in   1 = ticks may request a transaction; 0 = ticks ignored
//   iomem_valid  out  request valid
//   iomem_ready  in   responder acknowledge (one-cycle pulse)
//   iomem_wstrb  out  byte strobes, 4'b0000 = read
//   iomem_addr   out  request address
//   iomem_wdata  out  write data
//   iomem_rdata  in   read data, valid in the ready cycle
//   count        out  last acknowledged count value
//   busy         out  high whenever the sequencer is not idle
//   err          out  sticky, set when a transaction times out
//   overrun      out  sticky, set when a tick is dropped
//   err_clr      in   single-cycle pulse clearing err and overrun
// -----------------------------------------------------------------------------
module iomem_count_master #(
    parameter int unsigned TICK_CYCLES = 32'd16000000,
    parameter logic [31:0] GPIO_ADDR   = 32'h0300_0000,
    parameter int unsigned TIMEOUT     = 32'd64,
    parameter logic [15:0] COUNT_INIT  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic [15:0] count,
    output logic        busy,
    output logic        err,
    output logic        overrun,
    input  logic        err_clr
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 32'd2) ? $clog2(TICK_CYCLES) : 32'd1;
    localparam int unsigned WAIT_W = (TIMEOUT > 32'd2) ? $clog2(TIMEOUT) : 32'd1;
    localparam logic [TICK_W-1:0] TICK_RELOAD  = TICK_W'(TICK_CYCLES - 32'd1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EVAL = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // Sequencer state
    state_t              state_q,    state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic                pending_q,  pending_d;
    logic [WAIT_W-1:0]   wait_q,     wait_d;
    logic [2:0]          stat_q,     stat_d;

    // Registered outputs
    logic                valid_q,    valid_d;
    logic [3:0]          wstrb_q,    wstrb_d;
    logic [31:0]         addr_q,     addr_d;
    logic [31:0]         wdata_q,    wdata_d;
    logic [15:0]         count_q,    count_d;
    logic                busy_q,     busy_d;
    logic                err_q,      err_d;
    logic                overrun_q,  overrun_d;

    // Combinational helpers
    logic                tick_s;
    logic                start_s;
    logic                timeout_s;
    logic                drop_s;
    logic [15:0]         next_count_s;

    // Only the three status bits are meaningful; second_toggle is captured but
    // has no effect on counting.
    logic                unused_bits_s;
    assign unused_bits_s = ^{iomem_rdata[31:3], stat_q[0]};

    // Free-running tick generator: pulses for one cycle at zero, then reloads.
    always_comb begin
        tick_s = (tick_cnt_q == {TICK_W{1'b0}});
        if (tick_s) begin
            tick_cnt_d = TICK_RELOAD;
        end else begin
            tick_cnt_d = tick_cnt_q - TICK_W'(1'b1);
        end
    end

    // Sequencer next-state: status read, evaluate, count write, with timeout.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stat_d    = stat_q;
        count_d   = count_q;
        start_s   = 1'b0;
        timeout_s = 1'b0;
        if (stat_q[1]) begin
            next_count_s = count_q + 16'd1;
        end else begin
            next_count_s = count_q - 16'd1;
        end
        case (state_q)
            ST_IDLE: begin
                wait_d = {WAIT_W{1'b0}};
                if (pending_q) begin
                    start_s = 1'b1;
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                // ready is tested before expiry so a last-cycle ack still wins
                if (iomem_ready) begin
                    stat_d  = iomem_rdata[2:0];
                    state_d = ST_EVAL;
                end else if (wait_q == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1'b1);
                end
            end
            ST_EVAL: begin
                wait_d = {WAIT_W{1'b0}};
                if (stat_q[2]) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                // the value being written is held in wdata_q; commit it on ack
                if (iomem_ready) begin
                    count_d = wdata_q[15:0];
                    state_d = ST_IDLE;
                end else if (wait_q == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Pending tick latch and the two sticky status flags (set beats clear).
    always_comb begin
        // A tick is only dropped if the pending one is not being consumed now.
        drop_s = tick_s & enable & pending_q & ~start_s;
        if (tick_s && enable) begin
            pending_d = 1'b1;
        end else if (start_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Bus outputs derived from the next state so they are registered and
    // stay constant for the whole time valid is high.
    always_comb begin
        valid_d = (state_d == ST_RD) || (state_d == ST_WR);
        busy_d  = (state_d != ST_IDLE);
        if (valid_d) begin
            addr_d = GPIO_ADDR;
        end else begin
            addr_d = 32'h0000_0000;
        end
        if (state_d == ST_WR) begin
            wstrb_d = 4'b0011;
            if (state_q == ST_EVAL) begin
                wdata_d = {16'h0000, next_count_s};
            end else begin
                wdata_d = wdata_q;
            end
        end else begin
            wstrb_d = 4'b0000;
            wdata_d = 32'h0000_0000;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= TICK_RELOAD;
            pending_q  <= 1'b0;
            wait_q     <= {WAIT_W{1'b0}};
            stat_q     <= 3'b000;
            valid_q    <= 1'b0;
            wstrb_q    <= 4'b0000;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            count_q    <= COUNT_INIT;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            wait_q     <= wait_d;
            stat_q     <= stat_d;
            valid_q    <= valid_d;
            wstrb_q    <= wstrb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign iomem_valid = valid_q;
    assign iomem_wstrb = wstrb_q;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign count       = count_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_iomem_count_master.sv
// -----------------------------------------------------------------------------
// tb_iomem_count_master
//
// Bench for iomem_count_master. A responder answers the DUT with a chosen ack
// delay and status word; a transaction-level reference model tracks what the
// outputs must be and a compare process checks them every cycle. Directed
// phases pin the model with hand-computed literals, then a randomized phase
// exercises enable, status, ack delay, spurious ready, err_clr and reset.
// -----------------------------------------------------------------------------
module tb_iomem_count_master;

    localparam int          TICK  = 8;
    localparam int          TO    = 24;
    localparam logic [31:0] ADDR  = 32'h0300_0000;
    localparam logic [15:0] CINIT = 16'hFFFE;

    localparam int P_IDLE = 0;
    localparam int P_RD   = 1;
    localparam int P_EVAL = 2;
    localparam int P_WR   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        iomem_ready = 1'b0;
    logic [31:0] iomem_rdata = 32'h0;
    logic        err_clr = 1'b0;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [15:0] count;
    logic        busy;
    logic        err;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    // responder / stimulus knobs
    logic [2:0]  status = 3'b110;
    int          delay = 0;
    int          spur_pct = 0;
    int          vcnt = 0;
    int          max_run = 0;
    int          nreads = 0;
    int          nvalid = 0;
    logic [31:0] wlog[$];

    // reference model state
    bit          m_ok = 1'b0;
    int          m_age;
    bit          m_pend;
    int          m_ph;
    int          m_wait;
    logic [2:0]  m_stat;
    logic [15:0] m_next;
    logic [15:0] m_count;
    bit          m_err;
    bit          m_ovr;

    iomem_count_master #(
        .TICK_CYCLES (TICK),
        .GPIO_ADDR   (ADDR),
        .TIMEOUT     (TO),
        .COUNT_INIT  (CINIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .count       (count),
        .busy        (busy),
        .err         (err),
        .overrun     (overrun),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs presented for that clock.
    task automatic model_step(input bit rst, input bit en, input bit rdy,
                              input logic [31:0] rd, input bit clr);
        bit tick;
        bit took;
        bit ovr_hit;
        bit to_hit;
        if (rst) begin
            m_ok = 1'b1; m_age = 0; m_pend = 1'b0; m_ph = P_IDLE; m_wait = 0;
            m_stat = 3'b000; m_next = 16'h0; m_count = CINIT; m_err = 1'b0; m_ovr = 1'b0;
            return;
        end
        // tick falls on the TICK-th cycle after reset, then every TICK cycles
        tick = ((m_age % TICK) == TICK - 1);
        m_age++;
        took = (m_ph == P_IDLE) && m_pend;
        ovr_hit = 1'b0;
        to_hit = 1'b0;
        if (took) m_pend = 1'b0;
        if (tick && en) begin
            if (m_pend) ovr_hit = 1'b1;
            m_pend = 1'b1;
        end
        case (m_ph)
            P_IDLE: if (took) begin m_ph = P_RD; m_wait = 0; end
            P_RD: begin
                if (rdy) begin m_stat = rd[2:0]; m_ph = P_EVAL; end
                else if (m_wait == TO - 1) begin to_hit = 1'b1; m_ph = P_IDLE; end
                else m_wait++;
            end
            P_EVAL: begin
                if (m_stat[2]) begin
                    m_next = m_stat[1] ? m_count + 16'd1 : m_count - 16'd1;
                    m_ph = P_WR;
                    m_wait = 0;
                end else begin
                    m_ph = P_IDLE;
                end
            end
            P_WR: begin
                if (rdy) begin m_count = m_next; m_ph = P_IDLE; end
                else if (m_wait == TO - 1) begin to_hit = 1'b1; m_ph = P_IDLE; end
                else m_wait++;
            end
            default: m_ph = P_IDLE;
        endcase
        m_err = to_hit ? 1'b1 : (clr ? 1'b0 : m_err);
        m_ovr = ovr_hit ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    // Compare process: 1 time unit after every edge, DUT vs model.
    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            check("valid", 32'(iomem_valid), 32'((m_ph == P_RD) || (m_ph == P_WR)));
            check("busy", 32'(busy), 32'(m_ph != P_IDLE));
            check("count", 32'(count), 32'(m_count));
            check("err", 32'(err), 32'(m_err));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if ((m_ph == P_RD) || (m_ph == P_WR)) begin
                check("addr", iomem_addr, ADDR);
                check("wstrb", 32'(iomem_wstrb), (m_ph == P_WR) ? 32'h3 : 32'h0);
            end
            if (m_ph == P_WR) check("wdata", iomem_wdata, {16'h0000, m_next});
        end
    end

    // One clock of stimulus: responder decision, logging, model step, edge.
    task automatic cycle();
        logic [31:0] r;
        if (iomem_valid === 1'b1) begin
            vcnt++;
            nvalid++;
            iomem_ready = (vcnt == delay + 1);
        end else begin
            if (vcnt > max_run) max_run = vcnt;
            vcnt = 0;
            iomem_ready = (int'($urandom_range(0, 99)) < spur_pct);
        end
        r = $urandom();
        r[2:0] = status;
        iomem_rdata = r;
        if (iomem_ready && (iomem_valid === 1'b1)) begin
            if (iomem_wstrb == 4'b0011) wlog.push_back(iomem_wdata);
            else nreads++;
        end
        model_step(reset, enable, iomem_ready, iomem_rdata, err_clr);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        @(posedge clk);
        #2;
        repeat (2) cycle();
        reset = 1'b0;
        check("rst_count", 32'(count), 32'h0000_FFFE);
        check("rst_valid", 32'(iomem_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // counting up across the 0xFFFF -> 0x0000 wrap
        status = 3'b110; delay = 0; enable = 1'b1;
        repeat (30) cycle();
        enable = 1'b0;
        repeat (10) cycle();
        check("up_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("up_w0", wlog[0], 32'h0000_FFFF);
            check("up_w1", wlog[1], 32'h0000_0000);
            check("up_w2", wlog[2], 32'h0000_0001);
        end
        check("up_count", 32'(count), 32'h0000_0001);

        // counting down across the 0x0000 -> 0xFFFF wrap
        status = 3'b100; wlog.delete(); enable = 1'b1;
        repeat (16) cycle();
        enable = 1'b0;
        repeat (12) cycle();
        check("dn_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) check("dn_w1", wlog[1], 32'h0000_FFFF);
        check("dn_count", 32'(count), 32'h0000_FFFF);

        // stopped: reads only, count held
        status = 3'b000; wlog.delete(); nreads = 0; enable = 1'b1;
        repeat (16) cycle();
        enable = 1'b0;
        repeat (12) cycle();
        check("stop_nwrites", 32'(wlog.size()), 32'd0);
        check("stop_nreads", 32'(nreads), 32'd2);
        check("stop_count", 32'(count), 32'h0000_FFFF);

        // responder never answers: timeout
        status = 3'b110; delay = 1000; max_run = 0; enable = 1'b1;
        repeat (8) cycle();
        enable = 1'b0;
        repeat (40) cycle();
        check("to_err", 32'(err), 32'h1);
        check("to_valid_len", 32'(max_run), 32'd24);
        check("to_count", 32'(count), 32'h0000_FFFF);
        err_clr = 1'b1; cycle(); err_clr = 1'b0; cycle();
        check("to_err_clr", 32'(err), 32'h0);

        // slow responder: one tick absorbed by pending, next one dropped
        delay = 20; enable = 1'b1;
        repeat (24) cycle();
        enable = 1'b0;
        repeat (120) cycle();
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_err", 32'(err), 32'h0);
        check("ovr_count", 32'(count), 32'h0000_0001);
        err_clr = 1'b1; cycle(); err_clr = 1'b0; cycle();
        check("ovr_clr", 32'(overrun), 32'h0);

        // reset in the middle of a write
        delay = 5; status = 3'b110; enable = 1'b1; found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if ((iomem_valid === 1'b1) && (iomem_wstrb === 4'b0011)) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("mid_wr_found", 32'(found), 32'h1);
        reset = 1'b1; enable = 1'b0;
        cycle();
        reset = 1'b0;
        check("mid_wr_valid", 32'(iomem_valid), 32'h0);
        check("mid_wr_count", 32'(count), 32'h0000_FFFE);
        nvalid = 0;
        repeat (3 * TICK) cycle();
        check("disabled_no_valid", 32'(nvalid), 32'd0);

        // randomized traffic
        spur_pct = 5;
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) enable = ($urandom_range(0, 99) < 80);
            status = 3'($urandom());
            if (iomem_valid !== 1'b1) begin
                delay = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 26));
            end
            err_clr = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 399) == 0);
            cycle();
        end
        reset = 1'b0; err_clr = 1'b0; enable = 1'b0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
